seq_booth_mul: RTL and testbench

Parametrised sequential radix-4 Booth multiplier for the CPU datapath. It generalises the fixed 32-bit signed MUL path to any even WIDTH, adds signed and unsigned modes, and adds a start/busy/done handshake. It retires 2 multiplier bits per cycle and returns a 2*WIDTH product as hi and lo words, in the Zhigh/Zlow form the datapath already expects.

---
 rtl/seq_booth_mul_pkg.sv | 32 +++
 rtl/seq_booth_mul_recode.sv | 29 ++
 rtl/seq_booth_mul.sv | 137 +++++++++++++
 tb/tb_seq_booth_mul.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_booth_mul_pkg.sv
// Shared encodings for the sequential radix-4 Booth multiplier:
// FSM states and the Booth partial-product select codes.
package seq_booth_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      ZERO     = 3'd0,
      PLUS_M   = 3'd1,
      PLUS_2M  = 3'd2,
      MINUS_M  = 3'd3,
      MINUS_2M = 3'd4
   } booth_sel_e;

   // Window is {q[1], q[0], q[-1]}.
   function automatic booth_sel_e booth_decode(input logic [2:0] win);
      booth_sel_e sel;
      case (win)
         3'b001, 3'b010: sel = PLUS_M;
         3'b011:         sel = PLUS_2M;
         3'b100:         sel = MINUS_2M;
         3'b101, 3'b110: sel = MINUS_M;
         default:        sel = ZERO;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/seq_booth_mul_recode.sv
// Combinational radix-4 Booth recoder: 3-bit window and multiplicand in,
// signed addend (0, +-M, +-2M) out, all MW bits wide.
module booth_r4_recode
   import seq_booth_mul_pkg::*;
#(
   parameter int MW = 35
) (
   input  logic [2:0]    window,
   input  logic [MW-1:0] m,
   output logic [MW-1:0] addend
);

   logic [MW-1:0] m2;

   // m already carries two spare sign bits, so the shift cannot lose the sign.
   assign m2 = {m[MW-2:0], 1'b0};

   always_comb begin
      addend = '0;
      case (booth_decode(window))
         PLUS_M:   addend = m;
         PLUS_2M:  addend = m2;
         MINUS_M:  addend = -m;
         MINUS_2M: addend = -m2;
         default:  addend = '0;
      endcase
   end

endmodule

// File: rtl/seq_booth_mul.sv
// Sequential radix-4 Booth multiplier, signed or unsigned, 2 bits per cycle.
// done pulses WIDTH/2+2 cycles after start is taken; start is ignored while busy.
module seq_booth_mul
   import seq_booth_mul_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product_hi,
   output logic [WIDTH-1:0] product_lo
);

   localparam int XW    = WIDTH + 2;
   localparam int AW    = WIDTH + 3;
   localparam int STEPS = WIDTH / 2 + 1;
   localparam int CW    = $clog2(STEPS + 1);

   generate
      if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
         $error("seq_booth_mul: WIDTH must be even and >= 4");
      end
   endgenerate

   state_e          state_q, state_d;
   logic [AW-1:0]   a_q, a_d;
   logic [AW-1:0]   m_q, m_d;
   logic [XW-1:0]   q_q, q_d;
   logic            qm1_q, qm1_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic [AW-1:0]   addend;
   logic [AW-1:0]   sum;
   logic [AW-1:0]   a_sh;
   logic [XW-1:0]   q_sh;

   booth_r4_recode #(.MW(AW)) u_recode (
      .window ({q_q[1:0], qm1_q}),
      .m      (m_q),
      .addend (addend)
   );

   assign sum  = a_q + addend;
   assign a_sh = {{2{sum[AW-1]}}, sum[AW-1:2]};
   assign q_sh = {sum[1:0], q_q[XW-1:2]};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      m_d     = m_q;
      q_d     = q_q;
      qm1_d   = qm1_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               m_d     = is_signed ? {{3{multiplicand[WIDTH-1]}}, multiplicand}
                                   : {3'b000, multiplicand};
               q_d     = is_signed ? {{2{multiplier[WIDTH-1]}}, multiplier}
                                   : {2'b00, multiplier};
               a_d     = '0;
               qm1_d   = 1'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d   = a_sh;
            q_d   = q_sh;
            qm1_d = q_q[1];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(STEPS - 1)) begin
               // Low 2*WIDTH bits of {A,Q}: all of Q plus the bottom WIDTH-2 bits of A.
               {hi_d, lo_d} = {a_sh[WIDTH-3:0], q_sh};
               done_d       = 1'b1;
               state_d      = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= IDLE;
         a_q     <= '0;
         m_q     <= '0;
         q_q     <= '0;
         qm1_q   <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         m_q     <= m_d;
         q_q     <= q_d;
         qm1_q   <= qm1_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign product_hi = hi_q;
   assign product_lo = lo_q;

endmodule

// File: tb/tb_seq_booth_mul.sv
// Directed self-checking bench for seq_booth_mul at WIDTH=32 and WIDTH=8.
module tb_seq_booth_mul;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        clear;
   logic        start32, sgn32, busy32, done32;
   logic [31:0] m32, q32, hi32, lo32;
   logic        start8, sgn8, busy8, done8;
   logic [7:0]  m8, q8, hi8, lo8;

   int n_cmp = 0;
   int n_bad = 0;

   seq_booth_mul #(.WIDTH(32)) dut32 (
      .clock(clk), .clear(clear), .start(start32), .is_signed(sgn32),
      .multiplicand(m32), .multiplier(q32), .busy(busy32), .done(done32),
      .product_hi(hi32), .product_lo(lo32)
   );

   seq_booth_mul #(.WIDTH(8)) dut8 (
      .clock(clk), .clear(clear), .start(start8), .is_signed(sgn8),
      .multiplicand(m8), .multiplier(q8), .busy(busy8), .done(done8),
      .product_hi(hi8), .product_lo(lo8)
   );

   function automatic logic [63:0] prod_now(input bit w8);
      return w8 ? {24'b0, hi8, 24'b0, lo8} : {hi32, lo32};
   endfunction

   // Pulses start for one cycle, scrambles operands afterwards, and watches
   // until done. poke_k injects a 9x9 start in RUN cycle poke_k; clr_k asserts
   // clear in RUN cycle clr_k and returns on the following cycle.
   task automatic run_mul(input bit w8, input bit sgn, input logic [31:0] m,
                          input logic [31:0] q, input int poke_k, input int clr_k,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output int lat, output int busy_n, output bit held,
                          output bit idle_before);
      logic [63:0] prev;
      lat = 0; busy_n = 0; held = 1'b1; hi = '0; lo = '0;
      @(negedge clk);
      idle_before = w8 ? (!busy8 && !done8) : (!busy32 && !done32);
      prev = prod_now(w8);
      if (w8) begin start8 = 1'b1; sgn8 = sgn; m8 = m[7:0]; q8 = q[7:0]; end
      else    begin start32 = 1'b1; sgn32 = sgn; m32 = m; q32 = q; end
      @(negedge clk);
      start8 = 1'b0; start32 = 1'b0;
      m32 = 32'hDEADBEEF; q32 = 32'h13579BDF; sgn32 = ~sgn;
      m8  = 8'hA5;        q8  = 8'h3C;        sgn8  = ~sgn;
      for (int k = 1; k <= 60; k++) begin
         if (w8 ? busy8 : busy32) busy_n++;
         if (w8 ? done8 : done32) begin
            lat = k;
            hi  = w8 ? {24'b0, hi8} : hi32;
            lo  = w8 ? {24'b0, lo8} : lo32;
            break;
         end
         if (prod_now(w8) !== prev) held = 1'b0;
         if (k == clr_k) begin
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            return;
         end
         if (k == poke_k) begin
            if (w8) begin start8 = 1'b1; m8 = 8'd9; q8 = 8'd9; end
            else    begin start32 = 1'b1; m32 = 32'd9; q32 = 32'd9; end
         end else begin
            start8 = 1'b0; start32 = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      clear = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy32, done32, hi32, lo32} !== 66'd0) begin
         n_bad++;
         $display("FAIL reset32: got busy=%b done=%b hi=%h lo=%h expected all zero", busy32, done32, hi32, lo32);
      end
      n_cmp++;
      if ({busy8, done8, hi8, lo8} !== 18'd0) begin
         n_bad++;
         $display("FAIL reset8: got busy=%b done=%b hi=%h lo=%h expected all zero", busy8, done8, hi8, lo8);
      end
      clear = 1'b0;
   endtask

   task automatic test_signed_basic();
      logic [31:0] hi, lo; int lat, bn; bit held, idl;
      run_mul(1'b0, 1'b1, 32'hFFFFFFFB, 32'h00000006, 0, 0, hi, lo, lat, bn, held, idl);
      n_cmp++;
      if (lat !== 18) begin n_bad++; $display("FAIL neg5x6_latency: got %0d expected 18", lat); end
      n_cmp++;
      if (bn !== 18) begin n_bad++; $display("FAIL neg5x6_busy_cycles: got %0d expected 18", bn); end
      n_cmp++;
      if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFE2) begin
         n_bad++; $display("FAIL neg5x6_product: got %h_%h expected ffffffff_ffffffe2", hi, lo);
      end
      @(negedge clk);
      n_cmp++;
      if ({busy32, done32} !== 2'b00) begin
         n_bad++; $display("FAIL neg5x6_after_done: got busy=%b done=%b expected 0 0", busy32, done32);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({hi32, lo32} !== 64'hFFFFFFFF_FFFFFFE2) begin
         n_bad++; $display("FAIL neg5x6_hold_idle: got %h_%h expected ffffffff_ffffffe2", hi32, lo32);
      end
   endtask

   task automatic test_all_ones();
      logic [31:0] hi, lo; int lat, bn; bit held, idl;
      run_mul(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, hi, lo, lat, bn, held, idl);
      n_cmp++;
      if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
         n_bad++; $display("FAIL unsigned_ones: got %h_%h expected fffffffe_00000001", hi, lo);
      end
      n_cmp++;
      if (held !== 1'b1) begin n_bad++; $display("FAIL unsigned_ones_hold: got held=%b expected 1", held); end
      run_mul(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, hi, lo, lat, bn, held, idl);
      n_cmp++;
      if ({hi, lo} !== 64'h00000000_00000001) begin
         n_bad++; $display("FAIL signed_ones: got %h_%h expected 00000000_00000001", hi, lo);
      end
      n_cmp++;
      if (held !== 1'b1) begin n_bad++; $display("FAIL signed_ones_hold: got held=%b expected 1", held); end
   endtask

   task automatic test_min_signed();
      logic [31:0] hi, lo; int lat, bn; bit held, idl;
      run_mul(1'b0, 1'b1, 32'h80000000, 32'h80000000, 0, 0, hi, lo, lat, bn, held, idl);
      n_cmp++;
      if ({hi, lo} !== 64'h40000000_00000000) begin
         n_bad++; $display("FAIL min_signed_sq: got %h_%h expected 40000000_00000000", hi, lo);
      end
   endtask

   task automatic test_ignore_start();
      logic [31:0] hi, lo; int lat, bn; bit held, idl;
      run_mul(1'b0, 1'b0, 32'd3, 32'd7, 3, 0, hi, lo, lat, bn, held, idl);
      n_cmp++;
      if ({hi, lo} !== 64'd21) begin n_bad++; $display("FAIL ignore_start_product: got %h_%h expected 0_21", hi, lo); end
      n_cmp++;
      if (lat !== 18) begin n_bad++; $display("FAIL ignore_start_latency: got %0d expected 18", lat); end
      n_cmp++;
      if (held !== 1'b1) begin n_bad++; $display("FAIL ignore_start_hold: got held=%b expected 1", held); end
      run_mul(1'b0, 1'b0, 32'd9, 32'd9, 0, 0, hi, lo, lat, bn, held, idl);
      n_cmp++;
      if (idl !== 1'b1) begin n_bad++; $display("FAIL back_to_back_idle: got idle=%b expected 1", idl); end
      n_cmp++;
      if ({hi, lo} !== 64'd81) begin n_bad++; $display("FAIL back_to_back_product: got %h_%h expected 0_81", hi, lo); end
      n_cmp++;
      if (lat !== 18) begin n_bad++; $display("FAIL back_to_back_latency: got %0d expected 18", lat); end
   endtask

   task automatic test_abort();
      logic [31:0] hi, lo; int lat, bn, dn; bit held, idl;
      run_mul(1'b0, 1'b1, 32'hFFFFFFFB, 32'd6, 0, 5, hi, lo, lat, bn, held, idl);
      n_cmp++;
      if ({busy32, hi32, lo32} !== 65'd0) begin
         n_bad++; $display("FAIL abort_clear: got busy=%b hi=%h lo=%h expected all zero", busy32, hi32, lo32);
      end
      dn = 0;
      for (int k = 0; k < 30; k++) begin
         if (done32) dn++;
         @(negedge clk);
      end
      n_cmp++;
      if (dn !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d done pulses expected 0", dn); end
      run_mul(1'b0, 1'b0, 32'd2, 32'd3, 0, 0, hi, lo, lat, bn, held, idl);
      n_cmp++;
      if ({hi, lo} !== 64'd6) begin n_bad++; $display("FAIL abort_restart: got %h_%h expected 0_6", hi, lo); end
   endtask

   task automatic test_width8();
      logic [31:0] hi, lo; int lat, bn; bit held, idl;
      run_mul(1'b1, 1'b1, 32'h80, 32'h7F, 0, 0, hi, lo, lat, bn, held, idl);
      n_cmp++;
      if (lat !== 6) begin n_bad++; $display("FAIL w8_latency: got %0d expected 6", lat); end
      n_cmp++;
      if (bn !== 6) begin n_bad++; $display("FAIL w8_busy_cycles: got %0d expected 6", bn); end
      n_cmp++;
      if ({hi[7:0], lo[7:0]} !== 16'hC080) begin
         n_bad++; $display("FAIL w8_signed_min_max: got %h%h expected c080", hi[7:0], lo[7:0]);
      end
      run_mul(1'b1, 1'b0, 32'h80, 32'h7F, 0, 0, hi, lo, lat, bn, held, idl);
      n_cmp++;
      if ({hi[7:0], lo[7:0]} !== 16'h3F80) begin
         n_bad++; $display("FAIL w8_unsigned_128x127: got %h%h expected 3f80", hi[7:0], lo[7:0]);
      end
      run_mul(1'b1, 1'b0, 32'hFF, 32'hFF, 0, 0, hi, lo, lat, bn, held, idl);
      n_cmp++;
      if ({hi[7:0], lo[7:0]} !== 16'hFE01) begin
         n_bad++; $display("FAIL w8_unsigned_ff: got %h%h expected fe01", hi[7:0], lo[7:0]);
      end
      run_mul(1'b1, 1'b1, 32'h7F, 32'h7F, 0, 0, hi, lo, lat, bn, held, idl);
      n_cmp++;
      if ({hi[7:0], lo[7:0]} !== 16'h3F01) begin
         n_bad++; $display("FAIL w8_signed_7f: got %h%h expected 3f01", hi[7:0], lo[7:0]);
      end
   endtask

   initial begin
      clear = 1'b1;
      start32 = 1'b0; sgn32 = 1'b0; m32 = '0; q32 = '0;
      start8  = 1'b0; sgn8  = 1'b0; m8  = '0; q8  = '0;
      test_reset();
      test_signed_basic();
      test_all_ones();
      test_min_signed();
      test_ignore_start();
      test_abort();
      test_width8();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
